// File: rtl/palette_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : palette_pkg
//  Description : Shared types and constants for the sprite palette bank:
//                colour struct, transparency key, fade FSM states and the
//                reset-time species palettes.
//  Revision    : 1.0 - initial release
// ============================================================================
package palette_pkg;

    // Colour channels at the native 4-bit depth used by the default table.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam int c_DEF_BANKS   = 5;
    localparam int c_DEF_ENTRIES = 8;

    // Magenta-ish key colour that marks a pixel as see-through.
    localparam rgb_t KEY_RGB = 12'hE1E;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        HOLD     = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_t;

    // Five species palettes; entry 0 is the key colour in every bank so that
    // sprite backgrounds are transparent by default.
    localparam logic [11:0] DEFAULT_PALETTE [c_DEF_BANKS][c_DEF_ENTRIES] = '{
        '{12'hE1E, 12'hE1E, 12'hFFF, 12'hC94, 12'h8D4, 12'h4A2, 12'h963, 12'h222},
        '{12'hE1E, 12'h000, 12'hF80, 12'hC40, 12'h820, 12'hFD8, 12'hA64, 12'h555},
        '{12'hE1E, 12'hFFF, 12'h8CF, 12'h000, 12'h46A, 12'h9E4, 12'h2A2, 12'hDDD},
        '{12'hE1E, 12'h000, 12'hF0F, 12'hA0A, 12'h505, 12'hFFD, 12'hCC8, 12'h888},
        '{12'hE1E, 12'h000, 12'h4F4, 12'h2A2, 12'h8D4, 12'hC94, 12'hF44, 12'hAAA}
    };

    // Reset value of one palette slot; anything outside the table is key.
    function automatic rgb_t default_rgb(input int bank, input int entry);
        if (bank < c_DEF_BANKS && entry < c_DEF_ENTRIES)
            return rgb_t'(DEFAULT_PALETTE[3'(bank)][3'(entry)]);
        return KEY_RGB;
    endfunction

endpackage
`default_nettype wire

// File: rtl/palette_fade_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : palette_fade_fsm
//  Description : Frame-driven fade-to-black / hold / fade-in sequencer that
//                produces the brightness reduction applied to looked-up colours.
//  Revision    : 1.0 - initial release
// ============================================================================
module palette_fade_fsm
    import palette_pkg::*;
#(
    parameter int COLOR_W     = 4,
    parameter int FADE_STEP   = 4,
    parameter int HOLD_FRAMES = 30
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic               fade_start,
    output logic [COLOR_W-1:0] fade_level,
    output logic               fade_busy,
    output logic               fade_dark
);

    localparam int c_CNT_MAX = (FADE_STEP > HOLD_FRAMES) ? FADE_STEP : HOLD_FRAMES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [COLOR_W-1:0] c_LVL_MAX_M1 = {{(COLOR_W-1){1'b1}}, 1'b0};
    localparam logic [COLOR_W-1:0] c_LVL_ONE    = COLOR_W'(1);
    localparam logic [c_CNT_W-1:0] c_STEP_LAST  = c_CNT_W'(FADE_STEP - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(HOLD_FRAMES - 1);

    fade_state_t        r_state,  w_state_nxt;
    logic [COLOR_W-1:0] r_level,  w_level_nxt;
    logic [c_CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic               r_dark,   w_dark_nxt;

    // State, level, shared tick counter and dark pulse registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_level <= '0;
            r_cnt   <= '0;
            r_dark  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dark  <= w_dark_nxt;
        end
    end

    // Next-state logic; only ticks seen outside IDLE advance the counter, so a
    // tick coincident with the start pulse is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_cnt_nxt   = r_cnt;
        w_dark_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_level_nxt = '0;
                if (fade_start) begin
                    w_state_nxt = FADE_OUT;
                    w_cnt_nxt   = '0;
                end
            end
            FADE_OUT: begin
                if (frame_tick) begin
                    if (r_cnt == c_STEP_LAST) begin
                        w_cnt_nxt   = '0;
                        w_level_nxt = r_level + c_LVL_ONE;
                        if (r_level == c_LVL_MAX_M1) begin
                            w_state_nxt = HOLD;
                            w_dark_nxt  = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (frame_tick) begin
                    if (r_cnt == c_HOLD_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = FADE_IN;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            FADE_IN: begin
                if (frame_tick) begin
                    if (r_cnt == c_STEP_LAST) begin
                        w_cnt_nxt   = '0;
                        w_level_nxt = r_level - c_LVL_ONE;
                        if (r_level == c_LVL_ONE)
                            w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign fade_level = r_level;
    assign fade_busy  = (r_state != IDLE);
    assign fade_dark  = r_dark;

endmodule
`default_nettype wire

// File: rtl/sprite_palette_bank.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_palette_bank
//  Description : Multi-bank writable sprite palette with a two-stage lookup,
//                key-colour transparency and a saturating screen fade.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_palette_bank
    import palette_pkg::*;
#(
    parameter int  INDEX_W     = 3,
    parameter int  BANKS       = 8,
    parameter int  COLOR_W     = 4,
    parameter int  FADE_STEP   = 4,
    parameter int  HOLD_FRAMES = 30,
    localparam int BANK_W      = $clog2(BANKS)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   wr_en,
    input  logic [BANK_W-1:0]      wr_bank,
    input  logic [INDEX_W-1:0]     wr_index,
    input  logic [3*COLOR_W-1:0]   wr_rgb,
    input  logic                   rd_valid,
    input  logic [BANK_W-1:0]      rd_bank,
    input  logic [INDEX_W-1:0]     rd_index,
    input  logic                   frame_tick,
    input  logic                   fade_start,
    output logic                   out_valid,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   transparent,
    output logic                   fade_busy,
    output logic                   fade_dark
);

    localparam int c_ENTRIES = 2**INDEX_W;
    localparam int c_SLOTS   = 2**(BANK_W + INDEX_W);
    localparam int c_RGB_W   = 3*COLOR_W;

    // Rescale a native 4-bit channel to the configured channel depth.
    function automatic logic [COLOR_W-1:0] scale_chan(input logic [3:0] c);
        logic [31:0] v;
        v = {28'd0, c};
        if (COLOR_W >= 4) v = v << (COLOR_W - 4);
        else              v = v >> (4 - COLOR_W);
        return v[COLOR_W-1:0];
    endfunction

    function automatic logic [c_RGB_W-1:0] scale_rgb(input rgb_t c);
        return {scale_chan(c.r), scale_chan(c.g), scale_chan(c.b)};
    endfunction

    function automatic logic [COLOR_W-1:0] sat_sub(input logic [COLOR_W-1:0] a,
                                                   input logic [COLOR_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    localparam logic [c_RGB_W-1:0] c_KEY = scale_rgb(KEY_RGB);

    logic [c_RGB_W-1:0] w_slot [c_SLOTS];
    logic [COLOR_W-1:0] w_fade_level;

    // The address space is padded to a power of two; slots whose bank is
    // beyond BANKS read as the key colour, which makes them transparent.
    for (genvar s = 0; s < c_SLOTS; s++) begin : g_slot
        localparam int c_BANK  = s / c_ENTRIES;
        localparam int c_ENTRY = s % c_ENTRIES;
        if (c_BANK < BANKS) begin : g_reg
            localparam logic [c_RGB_W-1:0] c_INIT = scale_rgb(default_rgb(c_BANK, c_ENTRY));
            logic [c_RGB_W-1:0] r_entry;
            logic               w_hit;
            assign w_hit = wr_en && (wr_bank == BANK_W'(c_BANK))
                                 && (wr_index == INDEX_W'(c_ENTRY));
            // Palette entry: default on reset, overwritten by a matching write.
            always_ff @(posedge Clk) begin
                if (Reset)      r_entry <= c_INIT;
                else if (w_hit) r_entry <= wr_rgb;
            end
            assign w_slot[s] = r_entry;
        end else begin : g_pad
            assign w_slot[s] = c_KEY;
        end
    end

    logic [BANK_W+INDEX_W-1:0] w_rd_addr;
    logic                      r_s1_valid;
    logic [c_RGB_W-1:0]        r_s1_rgb;

    assign w_rd_addr = {rd_bank, rd_index};

    // Stage 1: capture the entry; storage still holds the pre-write value
    // here, giving read-before-write on a same-cycle collision.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1_valid <= 1'b0;
            r_s1_rgb   <= '0;
        end else begin
            r_s1_valid <= rd_valid;
            r_s1_rgb   <= w_slot[w_rd_addr];
        end
    end

    logic               w_trans;
    logic [COLOR_W-1:0] w_r, w_g, w_b;

    // Stage 2 colour math: key entries pass through, others are dimmed.
    always_comb begin
        w_trans = (r_s1_rgb == c_KEY);
        w_r     = r_s1_rgb[c_RGB_W-1 -: COLOR_W];
        w_g     = r_s1_rgb[2*COLOR_W-1 -: COLOR_W];
        w_b     = r_s1_rgb[COLOR_W-1:0];
        if (!w_trans) begin
            w_r = sat_sub(w_r, w_fade_level);
            w_g = sat_sub(w_g, w_fade_level);
            w_b = sat_sub(w_b, w_fade_level);
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid   <= 1'b0;
            transparent <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
        end else begin
            out_valid   <= r_s1_valid;
            transparent <= w_trans;
            red         <= w_r;
            green       <= w_g;
            blue        <= w_b;
        end
    end

    palette_fade_fsm #(
        .COLOR_W     (COLOR_W),
        .FADE_STEP   (FADE_STEP),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_fade (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .fade_start (fade_start),
        .fade_level (w_fade_level),
        .fade_busy  (fade_busy),
        .fade_dark  (fade_dark)
    );

endmodule
`default_nettype wire

// File: tb/tb_sprite_palette_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_palette_bank
//  Description : Directed self-checking bench for sprite_palette_bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_palette_bank;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        wr_en;
    logic [2:0]  wr_bank;
    logic [2:0]  wr_index;
    logic [11:0] wr_rgb;
    logic        rd_valid;
    logic [2:0]  rd_bank;
    logic [2:0]  rd_index;
    logic        frame_tick;
    logic        fade_start;
    logic        out_valid;
    logic [3:0]  red, green, blue;
    logic        transparent;
    logic        fade_busy;
    logic        fade_dark;

    int vectors    = 0;
    int miscompares = 0;
    int dark_cnt   = 0;

    logic [11:0] exp_b0 [8] = '{12'hE1E, 12'hE1E, 12'hFFF, 12'hC94,
                                12'h8D4, 12'h4A2, 12'h963, 12'h222};

    sprite_palette_bank #(
        .INDEX_W     (3),
        .BANKS       (8),
        .COLOR_W     (4),
        .FADE_STEP   (2),
        .HOLD_FRAMES (3)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .wr_en       (wr_en),
        .wr_bank     (wr_bank),
        .wr_index    (wr_index),
        .wr_rgb      (wr_rgb),
        .rd_valid    (rd_valid),
        .rd_bank     (rd_bank),
        .rd_index    (rd_index),
        .frame_tick  (frame_tick),
        .fade_start  (fade_start),
        .out_valid   (out_valid),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .transparent (transparent),
        .fade_busy   (fade_busy),
        .fade_dark   (fade_dark)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; everything is driven and sampled 1 time unit after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
        if (fade_dark) dark_cnt++;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic lookup(input string tag, input int bank, input int idx,
                          input logic [11:0] exp_rgb, input logic exp_tr);
        rd_valid = 1'b1;
        rd_bank  = 3'(bank);
        rd_index = 3'(idx);
        step();
        rd_valid = 1'b0;
        step();
        chk({tag, " valid"},  32'(out_valid),          32'd1);
        chk({tag, " rgb"},    32'({red, green, blue}), 32'(exp_rgb));
        chk({tag, " transp"}, 32'(transparent),        32'(exp_tr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1; wr_en = 1'b0; wr_bank = '0; wr_index = '0; wr_rgb = '0;
        rd_valid = 1'b0; rd_bank = '0; rd_index = '0;
        frame_tick = 1'b0; fade_start = 1'b0;
        step();
        // write attempted while in reset must be dropped
        wr_en = 1'b1; wr_bank = 3'd5; wr_index = 3'd4; wr_rgb = 12'h123;
        step();
        chk("rst out_valid", 32'(out_valid),          32'd0);
        chk("rst rgb",       32'({red, green, blue}), 32'd0);
        chk("rst transp",    32'(transparent),        32'd0);
        chk("rst busy",      32'(fade_busy),          32'd0);
        chk("rst dark",      32'(fade_dark),          32'd0);
        Reset = 1'b0; wr_en = 1'b0;
        step();

        lookup("rst-write ignored", 5, 4, 12'hE1E, 1'b1);
        lookup("b2e3", 2, 3, 12'h000, 1'b0);
        lookup("b0e1", 0, 1, 12'hE1E, 1'b1);

        // same-cycle write/read returns old data, next-cycle read sees new
        wr_en = 1'b1; wr_bank = 3'd5; wr_index = 3'd4; wr_rgb = 12'h9C3;
        rd_valid = 1'b1; rd_bank = 3'd5; rd_index = 3'd4;
        step();
        wr_en = 1'b0;
        step();
        chk("collide valid", 32'(out_valid),          32'd1);
        chk("collide rgb",   32'({red, green, blue}), 32'h0E1E);
        chk("collide transp",32'(transparent),        32'd1);
        rd_valid = 1'b0;
        step();
        chk("after-wr valid", 32'(out_valid),          32'd1);
        chk("after-wr rgb",   32'({red, green, blue}), 32'h09C3);
        chk("after-wr transp",32'(transparent),        32'd0);
        step();
        chk("idle valid", 32'(out_valid), 32'd0);

        // eight back-to-back lookups of bank 0, two-cycle latency each
        for (int j = 0; j < 10; j++) begin
            rd_valid = (j < 8);
            rd_bank  = 3'd0;
            rd_index = 3'(j);
            step();
            if (j >= 1 && j <= 8) begin
                chk($sformatf("b2b%0d valid", j-1), 32'(out_valid), 32'd1);
                chk($sformatf("b2b%0d rgb", j-1), 32'({red, green, blue}), 32'(exp_b0[j-1]));
                chk($sformatf("b2b%0d transp", j-1), 32'(transparent), 32'((j-1) < 2));
            end else begin
                chk($sformatf("b2b idle%0d", j), 32'(out_valid), 32'd0);
            end
        end
        rd_valid = 1'b0;

        // fade sequence 1: level 5, ignored restart, full dark, reset in HOLD
        dark_cnt = 0;
        fade_start = 1'b1;
        step();
        fade_start = 1'b0;
        chk("fade busy start", 32'(fade_busy), 32'd1);
        frames(10);
        lookup("lvl5 8D4", 0, 4, 12'h380, 1'b0);
        fade_start = 1'b1;
        step();
        fade_start = 1'b0;
        chk("restart busy", 32'(fade_busy), 32'd1);
        lookup("restart ignored", 0, 4, 12'h380, 1'b0);
        frames(19);
        chk("lvl14 dark_cnt", 32'(dark_cnt), 32'd0);
        lookup("lvl14 FFF", 0, 2, 12'h111, 1'b0);
        frames(1);
        chk("dark pulse once", 32'(dark_cnt), 32'd1);
        lookup("lvl15 C94", 0, 3, 12'h000, 1'b0);
        lookup("lvl15 key", 0, 0, 12'hE1E, 1'b1);
        chk("hold busy", 32'(fade_busy), 32'd1);
        frames(1);
        Reset = 1'b1;
        step();
        chk("hold reset busy", 32'(fade_busy), 32'd0);
        Reset = 1'b0;
        step();
        lookup("post-rst lvl0", 0, 4, 12'h8D4, 1'b0);
        lookup("post-rst bank5", 5, 4, 12'hE1E, 1'b1);

        // fade sequence 2: start with coincident tick, full cycle to IDLE
        dark_cnt = 0;
        fade_start = 1'b1; frame_tick = 1'b1;
        step();
        fade_start = 1'b0; frame_tick = 1'b0;
        step();
        frames(29);
        lookup("coinc tick dropped", 0, 2, 12'h111, 1'b0);
        frames(1);
        chk("dark pulse 2", 32'(dark_cnt), 32'd1);
        frames(3);
        frames(29);
        chk("fade-in busy", 32'(fade_busy), 32'd1);
        lookup("fade-in lvl1", 0, 2, 12'hEEE, 1'b0);
        frames(1);
        chk("fade done busy", 32'(fade_busy), 32'd0);
        lookup("fade done lvl0", 0, 2, 12'hFFF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
